y_rr_mux: RTL

- Parametrised, registered N-channel successor to the team's combinational 4-to-1 word mux.
- Arbitrates CHANNELS valid/ready input streams of SIZE-bit words onto one registered output stream.
- Arbitration mode is selectable: round-robin, fixed priority, or explicit select.
- Sits in front of shared datapath resources (ALU operand bus, register-file write port) where several producers compete.

---
 rtl/y_mux_pkg.sv | 19 +
 rtl/y_rr_pick.sv | 40 ++++
 rtl/y_rr_mux.sv | 123 ++++++++++++
 3 files changed

// File: rtl/y_mux_pkg.sv
// y_mux_pkg: shared constants and helpers for the y_rr_mux arbiter family.
//   Y_MODE_RR   - round-robin arbitration
//   Y_MODE_PRIO - fixed priority, lowest channel index wins
//   Y_MODE_SEL  - explicit channel select
//   y_clog2     - ceiling log2, used to size channel index fields
package y_mux_pkg;

  localparam int Y_MODE_RR   = 0;
  localparam int Y_MODE_PRIO = 1;
  localparam int Y_MODE_SEL  = 2;

  function automatic int y_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/y_rr_pick.sv
// y_rr_pick: combinational rotate-priority picker.
//   req [CHANNELS-1:0] - request vector
//   ptr [IW-1:0]       - highest-priority channel; must be < CHANNELS
//   gnt [CHANNELS-1:0] - one-hot grant (zero when no request)
//   idx [IW-1:0]       - index of the granted channel
//   any                - at least one request was granted
// Scans ptr, ptr+1, ... wrapping modulo CHANNELS. With ptr tied to 0 it
// degenerates into a lowest-index-wins priority encoder.
module y_rr_pick
  import y_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int IW       = y_clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [IW-1:0]       idx,
  output logic                any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      k = int'(ptr) + i;
      if (k >= CHANNELS) k = k - CHANNELS;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/y_rr_mux.sv
// y_rr_mux: registered N-channel valid/ready arbiter/mux.
//   clk, rst   - clock, asynchronous active-high reset
//   in_data    - CHANNELS flattened SIZE-bit words, channel k at [k*SIZE +: SIZE]
//   in_valid   - per-channel valid
//   in_ready   - per-channel accept, one-hot or zero
//   sel        - served channel in explicit-select mode, ignored otherwise
//   out_data   - registered selected word
//   out_chan   - channel that supplied out_data
//   out_valid  - out_data holds an unconsumed word
//   out_ready  - downstream accept
// Single-entry output register without skid buffer: a new word is accepted
// only when the register is empty or being drained in the same cycle.
module y_rr_mux
  import y_mux_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2,
  parameter int MODE     = Y_MODE_RR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS*SIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]      in_valid,
  output logic [CHANNELS-1:0]      in_ready,
  input  logic [SELW-1:0]          sel,
  output logic [SIZE-1:0]          out_data,
  output logic [SELW-1:0]          out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int PW = y_clog2(CHANNELS);

  logic [SIZE-1:0]     data_p1;
  logic [SELW-1:0]     chan_p1;
  logic                vld_p1;
  logic [PW-1:0]       ptr_p1;

  logic                load;
  logic [PW-1:0]       pick_ptr;
  logic [CHANNELS-1:0] pk_gnt;
  logic [PW-1:0]       pk_idx;
  logic                pk_any;
  logic [CHANNELS-1:0] sel_gnt;
  logic [PW-1:0]       sel_idx;
  logic [CHANNELS-1:0] gnt;
  logic [PW-1:0]       gidx;
  logic                any;
  logic [SIZE-1:0]     word;

  assign load     = !vld_p1 || out_ready;
  assign pick_ptr = (MODE == Y_MODE_RR) ? ptr_p1 : '0;

  y_rr_pick #(.CHANNELS(CHANNELS)) u_pick (
    .req (in_valid),
    .ptr (pick_ptr),
    .gnt (pk_gnt),
    .idx (pk_idx),
    .any (pk_any)
  );

  // Compare the full sel code against each real channel so codes
  // >= CHANNELS can never match and never index past in_valid.
  always_comb begin
    sel_gnt = '0;
    sel_idx = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SELW'(k) && in_valid[k]) begin
        sel_gnt[k] = 1'b1;
        sel_idx    = PW'(k);
      end
    end
  end

  always_comb begin
    gnt  = '0;
    gidx = '0;
    any  = 1'b0;
    word = '0;
    if (MODE == Y_MODE_SEL) begin
      any  = load && (|sel_gnt);
      gidx = sel_idx;
      if (any) gnt = sel_gnt;
    end else begin
      any  = load && pk_any;
      gidx = pk_idx;
      if (any) gnt = pk_gnt;
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (gnt[k]) word = in_data[k*SIZE +: SIZE];
    end
  end

  // Producers must not see an accept while the block is held in reset.
  assign in_ready = rst ? '0 : gnt;

  // ---- stage p1: output register and round-robin pointer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      ptr_p1  <= '0;
    end else begin
      if (load) begin
        vld_p1 <= any;
        if (any) begin
          data_p1 <= word;
          chan_p1 <= SELW'(gidx);
        end
      end
      if (MODE == Y_MODE_RR && any) begin
        ptr_p1 <= (int'(gidx) == CHANNELS - 1) ? '0 : gidx + PW'(1);
      end
    end
  end

  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign out_valid = vld_p1;

endmodule
